// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle core memory controller:
// state encoding, reset instruction and wait-counter width.
package mc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } mc_state_e;

    localparam logic [31:0]  NOP_INSTR  = 32'h00000013;
    localparam int unsigned  WAIT_CNT_W = 4;

    // Misaligned addresses and store-to-fetch combinations never reach the SRAM.
    function automatic logic is_rejected(input logic [1:0] byte_off,
                                         input logic       fetch,
                                         input logic       wr);
        return (byte_off != 2'b00) || (fetch && wr);
    endfunction

endpackage

// File: rtl/mc_if.sv
// Request/response and SRAM signals between the control FSM, the memory
// controller and the SRAM; the controller takes the slave view.
interface mc_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();

    logic                    req;
    logic                    is_fetch;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic                    ready;
    logic                    err;
    logic [DATA_WIDTH-1:0]   instr;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-3:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req, is_fetch, we, addr, wdata, mem_rdata,
        output ready, err, instr, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, is_fetch, we, addr, wdata, mem_rdata,
        input  ready, err, instr, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mc_wait_counter.sv
// Loadable down-counter timing the SRAM wait states; zero flags the
// cycle in which read data is valid.
module mc_wait_counter
    import mc_pkg::*;
#(
    parameter int unsigned WIDTH = WAIT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mc_mem_ctrl.sv
// Unified instruction/data memory controller: one fetch, load or store per
// request against a synchronous SRAM with a fixed wait-state count.
module mc_mem_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter int unsigned          ADDR_WIDTH  = 32,
    parameter int unsigned          WAIT_CYCLES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_INSTR = NOP_INSTR
) (
    input  logic clk,
    input  logic rst,
    mc_if.slave  bus
);

    mc_state_e               state;
    logic                    ready_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-3:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    lat_we;
    logic                    lat_fetch;
    logic                    cnt_zero;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    mc_wait_counter #(
        .WIDTH (WAIT_CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ACCESS),
        .load_val (WAIT_LOAD),
        .dec      (state == WAIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            instr_q     <= RESET_INSTR;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_we      <= 1'b0;
            lat_fetch   <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        // mem_addr/mem_wdata double as the latched request fields.
                        mem_addr_q  <= bus.addr[ADDR_WIDTH-1:2];
                        mem_wdata_q <= bus.wdata;
                        lat_we      <= bus.we;
                        lat_fetch   <= bus.is_fetch;
                        if (is_rejected(bus.addr[1:0], bus.is_fetch, bus.we)) begin
                            state   <= DONE;
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state    <= ACCESS;
                            mem_en_q <= 1'b1;
                            mem_we_q <= bus.we;
                        end
                    end
                end
                ACCESS: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        if (!lat_we) begin
                            if (lat_fetch) begin
                                instr_q <= bus.mem_rdata;
                            end else begin
                                rdata_q <= bus.mem_rdata;
                            end
                        end
                        state   <= DONE;
                        ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.instr     = instr_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mc_mem_ctrl.sv
// Directed bench for mc_mem_ctrl: one instance with one wait state, one
// with three; SRAM read data is driven by hand in the capture cycle.
module tb_mc_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1;
    logic        req3;
    logic        is_fetch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    always #5 clk = ~clk;

    mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b1 ();
    mc_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b3 ();

    assign b1.req       = req1;
    assign b1.is_fetch  = is_fetch;
    assign b1.we        = we;
    assign b1.addr      = addr;
    assign b1.wdata     = wdata;
    assign b1.mem_rdata = mem_rdata;

    assign b3.req       = req3;
    assign b3.is_fetch  = is_fetch;
    assign b3.we        = we;
    assign b3.addr      = addr;
    assign b3.wdata     = wdata;
    assign b3.mem_rdata = mem_rdata;

    mc_mem_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .WAIT_CYCLES (1),
        .RESET_INSTR (32'h00000013)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    mc_mem_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .WAIT_CYCLES (3),
        .RESET_INSTR (32'h00000013)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req1 = 1'b0; req3 = 1'b0; is_fetch = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; mem_rdata = JUNK;
        tick(); tick();
        chk("rst_ready",     32'(b1.ready),     32'd0);
        chk("rst_err",       32'(b1.err),       32'd0);
        chk("rst_mem_en",    32'(b1.mem_en),    32'd0);
        chk("rst_mem_we",    32'(b1.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(b1.mem_addr),  32'd0);
        chk("rst_mem_wdata", b1.mem_wdata,      32'd0);
        chk("rst_instr",     b1.instr,          32'h00000013);
        chk("rst_rdata",     b1.rdata,          32'd0);
        rst = 1'b0;
        tick();

        // Reset for two cycles in the middle of a W=3 fetch
        req3 = 1'b1; is_fetch = 1'b1; we = 1'b0; addr = 32'h80;
        tick();
        req3 = 1'b0;
        chk("mid_access_en", 32'(b3.mem_en), 32'd1);
        tick();
        rst = 1'b1; mem_rdata = 32'h12345678;
        tick();
        chk("mid_rst_ready", 32'(b3.ready),  32'd0);
        chk("mid_rst_instr", b3.instr,       32'h00000013);
        chk("mid_rst_en",    32'(b3.mem_en), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(b3.ready), 32'd0);
        chk("post_rst_instr", b3.instr,      32'h00000013);
        chk("post_rst_en",    32'(b3.mem_en), 32'd0);
        mem_rdata = JUNK;

        // Fetch, W=1
        req1 = 1'b1; is_fetch = 1'b1; we = 1'b0; addr = 32'h0000_0040;
        tick();
        req1 = 1'b0;
        chk("f1_mem_en",   32'(b1.mem_en),   32'd1);
        chk("f1_mem_we",   32'(b1.mem_we),   32'd0);
        chk("f1_mem_addr", 32'(b1.mem_addr), 32'h10);
        tick();
        mem_rdata = 32'h00500093;
        chk("f1_wait_en",    32'(b1.mem_en), 32'd0);
        chk("f1_wait_ready", 32'(b1.ready),  32'd0);
        tick();
        mem_rdata = JUNK;
        chk("f1_ready", 32'(b1.ready), 32'd1);
        chk("f1_err",   32'(b1.err),   32'd0);
        chk("f1_instr", b1.instr,      32'h00500093);
        chk("f1_rdata", b1.rdata,      32'd0);
        tick();
        chk("f1_ready_off", 32'(b1.ready), 32'd0);
        chk("f1_instr_hold", b1.instr,     32'h00500093);

        // Store, W=3
        req3 = 1'b1; is_fetch = 1'b0; we = 1'b1; addr = 32'h100; wdata = 32'hDEADBEEF;
        tick();
        req3 = 1'b0; we = 1'b0; wdata = '0;
        chk("st_mem_en",    32'(b3.mem_en),   32'd1);
        chk("st_mem_we",    32'(b3.mem_we),   32'd1);
        chk("st_mem_addr",  32'(b3.mem_addr), 32'h40);
        chk("st_mem_wdata", b3.mem_wdata,     32'hDEADBEEF);
        tick();
        chk("st_wait_we", 32'(b3.mem_we), 32'd0);
        chk("st_wait_en", 32'(b3.mem_en), 32'd0);
        tick();
        tick();
        chk("st_c4_ready", 32'(b3.ready), 32'd0);
        tick();
        chk("st_ready", 32'(b3.ready), 32'd1);
        chk("st_err",   32'(b3.err),   32'd0);
        chk("st_rdata", b3.rdata,      32'd0);
        tick();

        // Load back, W=3
        req3 = 1'b1; is_fetch = 1'b0; we = 1'b0; addr = 32'h100;
        tick();
        req3 = 1'b0;
        chk("ld_mem_en",   32'(b3.mem_en),   32'd1);
        chk("ld_mem_we",   32'(b3.mem_we),   32'd0);
        chk("ld_mem_addr", 32'(b3.mem_addr), 32'h40);
        tick();
        tick();
        tick();
        mem_rdata = 32'hDEADBEEF;
        chk("ld_c4_ready", 32'(b3.ready), 32'd0);
        tick();
        mem_rdata = JUNK;
        chk("ld_ready", 32'(b3.ready), 32'd1);
        chk("ld_rdata", b3.rdata,      32'hDEADBEEF);
        chk("ld_instr", b3.instr,      32'h00000013);
        tick();

        // Misaligned load, W=3
        req3 = 1'b1; is_fetch = 1'b0; we = 1'b0; addr = 32'h102;
        tick();
        req3 = 1'b0;
        chk("mis_ready",  32'(b3.ready),  32'd1);
        chk("mis_err",    32'(b3.err),    32'd1);
        chk("mis_mem_en", 32'(b3.mem_en), 32'd0);
        chk("mis_rdata",  b3.rdata,       32'hDEADBEEF);
        tick();
        chk("mis_ready_off", 32'(b3.ready),  32'd0);
        chk("mis_err_off",   32'(b3.err),    32'd0);
        chk("mis_mem_en2",   32'(b3.mem_en), 32'd0);

        // Illegal fetch-store, W=1
        req1 = 1'b1; is_fetch = 1'b1; we = 1'b1; addr = 32'h200;
        tick();
        req1 = 1'b0;
        chk("ill_ready",  32'(b1.ready),  32'd1);
        chk("ill_err",    32'(b1.err),    32'd1);
        chk("ill_mem_en", 32'(b1.mem_en), 32'd0);
        chk("ill_mem_we", 32'(b1.mem_we), 32'd0);
        chk("ill_instr",  b1.instr,       32'h00500093);
        tick();
        chk("ill_mem_en2", 32'(b1.mem_en), 32'd0);

        // Back-to-back loads, W=1, req held through ready
        req1 = 1'b1; is_fetch = 1'b0; we = 1'b0; addr = 32'h300;
        tick();
        chk("bb_a1_en",   32'(b1.mem_en),   32'd1);
        chk("bb_a1_addr", 32'(b1.mem_addr), 32'hC0);
        addr = 32'h3F0;
        tick();
        mem_rdata = 32'hCAFE0001;
        chk("bb_w1_addr", 32'(b1.mem_addr), 32'hC0);
        tick();
        mem_rdata = JUNK; addr = 32'h400;
        chk("bb_r1_ready", 32'(b1.ready), 32'd1);
        chk("bb_r1_rdata", b1.rdata,      32'hCAFE0001);
        tick();
        chk("bb_idle_en",    32'(b1.mem_en), 32'd0);
        chk("bb_idle_ready", 32'(b1.ready),  32'd0);
        tick();
        req1 = 1'b0;
        chk("bb_a2_en",   32'(b1.mem_en),   32'd1);
        chk("bb_a2_addr", 32'(b1.mem_addr), 32'h100);
        tick();
        req1 = 1'b1; addr = 32'h800; mem_rdata = 32'h13579BDF;
        chk("bb_w2_addr", 32'(b1.mem_addr), 32'h100);
        tick();
        req1 = 1'b0; mem_rdata = JUNK;
        chk("bb_r2_ready", 32'(b1.ready),    32'd1);
        chk("bb_r2_rdata", b1.rdata,         32'h13579BDF);
        chk("bb_r2_addr",  32'(b1.mem_addr), 32'h100);
        tick();
        chk("bb_end_ready", 32'(b1.ready),  32'd0);
        chk("bb_end_en",    32'(b1.mem_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mem_ctrl.md
Name: mc_mem_ctrl

Overview:
- Unified instruction/data memory controller for the RISC-V multicycle core; sits directly downstream of the control FSM.
- The FSM issues one request per access: instruction fetch, load, or store. The block drives a synchronous single-port SRAM with a fixed, configurable wait-state count.
- For reads it captures the returned word into the instruction register (fetch) or the data register (load), then signals completion with a one-cycle ready pulse.

Parameters:
- DATA_WIDTH, 32, width of the data word and of the instruction.
- ADDR_WIDTH, 32, byte-address width.
- WAIT_CYCLES, 1, cycles from the SRAM enable cycle to a valid mem_rdata; legal range 1..15.
- RESET_INSTR, 32'h00000013, instruction-register reset value (ADDI x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- is_fetch  in  1  1 = instruction fetch (capture to instr), 0 = data access.
- we  in  1  1 = store, 0 = read.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data.
- ready  out  1  one-cycle completion pulse.
- err  out  1  high together with ready when the access was rejected.
- instr  out  DATA_WIDTH  instruction register.
- rdata  out  DATA_WIDTH  data register (MDR).
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_WIDTH-2  SRAM word address, equal to addr[ADDR_WIDTH-1:2].
- mem_wdata  out  DATA_WIDTH  SRAM write data.
- mem_rdata  in  DATA_WIDTH  SRAM read data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - ready=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - instr=RESET_INSTR, rdata=0, wait counter=0.
- Reset mid-operation: aborts the access immediately.
  - No capture and no ready pulse.
  - mem_we is asserted only in ACCESS, so a store is either fully issued or not issued at all.
- States: IDLE, ACCESS, WAIT, DONE. All outputs are registered or decoded from registered state.
- IDLE:
  - On req=1, latch addr, wdata, we, is_fetch.
  - Rejection cases, which go straight to DONE with err=1:
    - addr[1:0] != 0 (misaligned);
    - is_fetch=1 and we=1 (illegal).
    - In both cases mem_en is never asserted.
  - Otherwise go to ACCESS. With req=0, stay in IDLE.
- ACCESS: one cycle.
  - mem_en=1, mem_we=latched we, mem_addr=latched word address, mem_wdata=latched wdata.
  - Load counter with WAIT_CYCLES-1, then go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0.
  - Counter decrements each cycle.
  - When the counter is 0:
    - if the access is a read, capture mem_rdata into instr when is_fetch=1, otherwise into rdata;
    - go to DONE.
  - Stores capture nothing.
- DONE: one cycle.
  - ready=1; err=1 only for rejected accesses.
  - Next state is always IDLE.
- Latency, with req accepted in cycle 0:
  - ACCESS in cycle 1; WAIT in cycles 2..WAIT_CYCLES+1; ready in cycle WAIT_CYCLES+2.
  - Rejected accesses: ready+err in cycle 1.
- Register update timing: instr and rdata change only at the capture edge, so their new value is visible in the same cycle as ready. They hold at all other times, including across stores and rejected accesses.
- req handshake:
  - Level-sensitive and ignored outside IDLE.
  - The requester must deassert req in the ready cycle. A req still high in the cycle after DONE starts a new access (back-to-back is legal).
- Inputs changing during ACCESS, WAIT or DONE have no effect, because the values are latched.

Decomposition:
- Shared package mc_pkg holds:
  - state encoding localparams: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - NOP_INSTR=32'h00000013;
  - WAIT_CNT_W=4.
- One natural sub-module, mc_wait_counter: loadable down-counter with a zero flag and inputs load, load_val, dec.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT of a fetch -> ready=0, instr=32'h00000013, mem_en=0 on the cycle after; no capture.
- Fetch, WAIT_CYCLES=1: req, is_fetch=1, addr=32'h0000_0040 with the SRAM returning 32'h00500093 -> mem_en=1 and mem_addr=30'h10 in cycle 1; ready in cycle 3; instr=32'h00500093; rdata unchanged.
- Store then load, WAIT_CYCLES=3:
  - store 32'hDEADBEEF to addr 32'h100 -> mem_we=1 only in ACCESS; ready at cycle 5; rdata unchanged.
  - load from 32'h100 -> rdata=32'hDEADBEEF at its ready cycle; instr unchanged.
- Misaligned: load at addr 32'h102 -> ready=1 and err=1 in cycle 1; mem_en never asserted; rdata unchanged.
- Illegal: is_fetch=1, we=1 -> ready+err in cycle 1, no SRAM activity.
- Back-to-back: req held high through ready -> a second ACCESS begins 2 cycles after ready; req toggled during WAIT -> no effect on latched addr or on mem_addr.
